dwell_out: RTL and testbench

DWELL_OUT -- requirements
Module: dwell_out

---
 rtl/dwell_pkg.sv | 11 +
 rtl/dwell_cnt.sv | 33 +++
 rtl/dwell_out.sv | 91 +++++++++
 tb/tb_dwell_out.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dwell_pkg.sv
// Shared types for the dwell-limited output block.
package dwell_pkg;

    typedef enum logic [1:0] {
        LO_IDLE = 2'b00,
        LO_HOLD = 2'b01,
        HI_IDLE = 2'b10,
        HI_HOLD = 2'b11
    } dwell_state_e;

endpackage

// File: rtl/dwell_cnt.sv
// Loadable down-counter that stops at zero and reports whether it is still running.
module dwell_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         nonzero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/dwell_out.sv
// Output follows a requested level (or a stretched pulse) but holds each level
// for at least DWELL cycles after every toggle.
module dwell_out
    import dwell_pkg::*;
#(
    parameter int DWELL_W = 16,
    parameter int DWELL   = 1000,
    parameter int STRETCH = 500,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    input  logic pulse_i,
    output logic data_o,
    output logic busy_o
);

    // Both counters are loaded one short: the loading cycle itself counts as
    // the first cycle of the hold / stretch interval.
    localparam logic [DWELL_W-1:0] DWELL_LD   = DWELL_W'(DWELL - 1);
    localparam logic [DWELL_W-1:0] STRETCH_LD = DWELL_W'(STRETCH - 1);
    localparam dwell_state_e       RST_STATE  = RST_VAL ? HI_IDLE : LO_IDLE;

    dwell_state_e state_q, state_d;
    logic         dwell_load;
    logic         dwell_nz;
    logic         stretch_nz;
    logic         stretch_active;
    logic         req;

    dwell_cnt #(.W(DWELL_W)) u_dwell_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (dwell_load),
        .value_i   (DWELL_LD),
        .nonzero_o (dwell_nz)
    );

    dwell_cnt #(.W(DWELL_W)) u_stretch_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (pulse_i),
        .value_i   (STRETCH_LD),
        .nonzero_o (stretch_nz)
    );

    assign stretch_active = pulse_i | stretch_nz;
    assign req            = level_i | stretch_active;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // req is only looked at in the IDLE states; HOLD ignores it entirely.
    always_comb begin
        state_d    = state_q;
        dwell_load = 1'b0;
        case (state_q)
            LO_IDLE: begin
                if (req) begin
                    state_d    = HI_HOLD;
                    dwell_load = 1'b1;
                end
            end
            HI_IDLE: begin
                if (!req) begin
                    state_d    = LO_HOLD;
                    dwell_load = 1'b1;
                end
            end
            LO_HOLD: begin
                if (!dwell_nz) state_d = LO_IDLE;
            end
            HI_HOLD: begin
                if (!dwell_nz) state_d = HI_IDLE;
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_comb begin
        data_o = (state_q == HI_IDLE) || (state_q == HI_HOLD);
        busy_o = (state_q == LO_HOLD) || (state_q == HI_HOLD);
    end

endmodule

// File: tb/tb_dwell_out.sv
// Randomised and directed bench for dwell_out against a timestamp-based model.
module tb_dwell_out;

    localparam int DWELL   = 4;
    localparam int STRETCH = 6;

    logic clk     = 1'b0;
    logic rst_i   = 1'b1;
    logic level_i = 1'b0;
    logic pulse_i = 1'b0;
    logic data_o;
    logic busy_o;

    always #5 clk = ~clk;

    dwell_out #(
        .DWELL_W (16),
        .DWELL   (DWELL),
        .STRETCH (STRETCH),
        .RST_VAL (1'b0)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .level_i (level_i),
        .pulse_i (pulse_i),
        .data_o  (data_o),
        .busy_o  (busy_o)
    );

    logic [1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Model: remembers when the output may next change and when the last pulse came.
    int   mc         = 0;
    logic m_valid    = 1'b0;
    logic m_data     = 1'b0;
    logic m_busy     = 1'b0;
    int   hold_until = 0;
    int   last_pulse = -1000;

    task automatic model_update(input logic r, input logic l, input logic p);
        logic req;
        if (r) begin
            m_data     = 1'b0;
            m_busy     = 1'b0;
            hold_until = mc + 1;
            last_pulse = -1000;
            m_valid    = 1'b1;
        end else begin
            if (p) last_pulse = mc;
            req = l | ((mc - last_pulse) < STRETCH);
            if (mc >= hold_until && req != m_data) begin
                m_data     = req;
                hold_until = mc + 1 + DWELL;
            end
            m_busy = (mc + 1) < hold_until;
        end
        mc++;
    endtask

    task automatic step(input logic r, input logic l, input logic p);
        @(posedge clk);
        #1;
        if (m_valid) exp_q.push_back({m_data, m_busy});
        rst_i   = r;
        level_i = l;
        pulse_i = p;
        model_update(r, l, p);
    endtask

    task automatic hold_inputs(input int n, input logic l);
        for (int i = 0; i < n; i++) step(1'b0, l, 1'b0);
    endtask

    // Monitor: compares every cycle and also checks minimum run length between toggles.
    logic       prev_data = 1'b0;
    logic       rst_prev  = 1'b1;
    logic       run_ok    = 1'b0;
    int         run_len   = 0;
    logic [1:0] e;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({data_o, busy_o} !== e) begin
                n_fail++;
                $display("FAIL out_cmp t=%0t data_o/busy_o=%b%b expected=%b%b",
                         $time, data_o, busy_o, e[1], e[0]);
            end
        end
        if (data_o !== prev_data) begin
            if (!rst_prev && run_ok) begin
                n_checks++;
                if (run_len < DWELL + 1) begin
                    n_fail++;
                    $display("FAIL min_run t=%0t run=%0d required>=%0d",
                             $time, run_len, DWELL + 1);
                end
            end
            run_len = 1;
            run_ok  = !rst_prev;
        end else begin
            run_len++;
        end
        if (rst_i) run_ok = 1'b0;
        prev_data = data_o;
        rst_prev  = rst_i;
    end

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);

        // Rise and settle high, then fall.
        hold_inputs(9, 1'b0);
        hold_inputs(10, 1'b1);
        hold_inputs(10, 1'b0);

        // Single-cycle level request gives a DWELL+1 wide high.
        step(1'b0, 1'b1, 1'b0);
        hold_inputs(10, 1'b0);

        // A short dip during HOLD is absorbed.
        hold_inputs(2, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        hold_inputs(8, 1'b1);
        hold_inputs(10, 1'b0);

        // Pulse stretch and retrigger.
        step(1'b0, 1'b0, 1'b1);
        hold_inputs(3, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        hold_inputs(12, 1'b0);

        // Reset in the middle of HOLD with level still requested.
        hold_inputs(2, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        hold_inputs(8, 1'b1);
        hold_inputs(10, 1'b0);

        // Pulse coinciding with a level change, then reset mid-stretch.
        step(1'b0, 1'b1, 1'b1);
        hold_inputs(2, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        hold_inputs(10, 1'b0);

        begin
            logic l = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 7) == 0) l = ~l;
                step(($urandom_range(0, 399) == 0), l,
                     ($urandom_range(0, 19) == 0));
            end
        end
        hold_inputs(3, 1'b0);

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain queue_left=%0d expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
